pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipelined RISC-V core. It watches the IF/ID, ID/EX, EX and MEM stages and drives the write-enables and flushes of the PC and the pipeline registers. It handles three events:
- load-use hazards;
- branch mispredictions resolved in EX, from the bimodal predictor's `predictionEX` vs the actual outcome;
- multi-cycle data-memory wait states.

It also detects a hung memory and keeps saturating performance counters for stalls and flushes.

## Interface
Parameters:
- `CNT_W`, 32, width of the `stall_cnt` and `flush_cnt` counters.
- `MEM_TIMEOUT`, 16, number of consecutive MEM wait cycles that forces the HALT state (≥2).

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in IF/ID.
- `id_uses_rs2`  in  1  the ID instruction reads rs2 (R-type, store, branch).
- `ex_mem_read`  in  1  the instruction in ID/EX is a load.
- `ex_rd`  in  5  destination register of the ID/EX instruction.
- `ex_branch`  in  1  the ID/EX instruction is a conditional branch.
- `ex_predicted`  in  1  prediction carried with that branch.
- `ex_taken`  in  1  actual branch outcome computed in EX.
- `mem_req`  in  1  the MEM stage holds a load or store.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_en`  out  1  PC register write enable.
- `ifid_en`  out  1  IF/ID write enable.
- `ifid_flush`  out  1  IF/ID loads a NOP.
- `idex_en`  out  1  ID/EX write enable.
- `idex_flush`  out  1  ID/EX loads a bubble, with all control bits cleared.
- `exmem_en`  out  1  EX/MEM write enable.
- `memwb_bubble`  out  1  MEM/WB captures a bubble, with `RegWrite` cleared.
- `redirect`  out  1  PC mux selects the corrected branch target.
- `mem_err`  out  1  sticky memory-timeout flag.
- `state`  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 HALT.
- `stall_cnt`  out  `CNT_W`  count of stall cycles.
- `flush_cnt`  out  `CNT_W`  count of misprediction flushes.

## Operation
- **Default outputs** (no event, RUN): `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=1; all other control outputs are 0.
- **Event priority** within a cycle: FREEZE > MISPREDICT > LOAD-USE. A lower-priority event is fully suppressed when a higher one is active.
- **FREEZE**: active when `state`=MEM_WAIT, or when `mem_req`=1 and `mem_ready`=0 in RUN.
  - `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=0 and `memwb_bubble`=1.
  - A branch held in EX is not acted on until the freeze clears. It is then re-evaluated with its current inputs.
- **MISPREDICT**: active when `ex_branch` & (`ex_predicted`≠`ex_taken`).
  - `redirect`=1, `ifid_flush`=1, `idex_flush`=1, `pc_en`=1.
  - A load-use hazard in the same cycle is ignored, because the ID instruction is being flushed.
- **LOAD-USE**: active when `ex_mem_read` & `ex_rd`≠0 & (`ex_rd`==`id_rs1` | (`id_uses_rs2` & `ex_rd`==`id_rs2`)).
  - `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  - `ex_rd`=x0 never stalls.
- **FSM transitions**:
  - RUN→MEM_WAIT when `mem_req` & !`mem_ready`; `wait_cnt` is set to 1.
  - MEM_WAIT→RUN when `mem_ready`=1. The freeze still applies in that completing cycle, and `wait_cnt` is cleared.
  - MEM_WAIT, with `mem_ready`=0: `wait_cnt` increments. When it reaches `MEM_TIMEOUT`, the FSM goes to HALT and `mem_err` is set.
  - HALT is entered only from MEM_WAIT and is left only by reset. In HALT, every enable is 0, every flush and redirect is 0, and `memwb_bubble`=1.
- **Counters** (saturating: they hold at all-ones, no wrap):
  - `stall_cnt` increments once in every cycle with FREEZE or LOAD-USE, including HALT cycles.
  - `flush_cnt` increments once per MISPREDICT cycle.

## Timing
- Control outputs are combinational (Mealy) from the registered `state` and the current inputs. There is zero-cycle latency from hazard to stall.
- `state`, `wait_cnt`, `mem_err` and both counters update on the rising edge of `clk`. Counters show an event on the edge after the event cycle.
- **Asynchronous reset** (`reset`=0):
  - `state`=RUN, `wait_cnt`=0, `mem_err`=0, `stall_cnt`=0, `flush_cnt`=0, immediately with no clock edge needed.
  - Control outputs then follow the RUN rules for the inputs present.
- **Reset mid-wait or in HALT**: the block returns to RUN immediately, and the error flag clears.
- **Load-use stall length**: exactly one cycle, because the load advances to MEM and the hazard condition clears. A new hazard in the next cycle produces another independent stall.
- **Back-to-back mispredicts**: each cycle is handled independently, and `flush_cnt` increments once per cycle.
- **Memory access**: a single-cycle access (`mem_ready`=1 in the same cycle as `mem_req`) causes no freeze and no state change.

## Test plan
- **Load-use hazard**: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5 for one cycle.
  - Expect `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  - Expect `stall_cnt` 0→1 on the next edge.
  - Repeat with `ex_rd`=0 and expect no stall.
- **Mispredict with a coincident load-use**: `ex_branch`=1, `ex_predicted`=1, `ex_taken`=0, with load-use also true.
  - Expect `redirect`=`ifid_flush`=`idex_flush`=1, `pc_en`=1, `flush_cnt`=1, `stall_cnt` unchanged.
- **Memory wait of 3 cycles**: `mem_req`=1 with `mem_ready` low for 3 cycles, then high.
  - Expect `state` 00→01 after the first edge.
  - Expect freeze outputs for 4 cycles in total, `state` back to 00, and `stall_cnt`=4.
- **Memory timeout**: `MEM_TIMEOUT`=4, `mem_ready` held at 0.
  - Expect `state`=10 and `mem_err`=1 after the 4th edge.
  - Expect all enables to stay 0 while stimulus continues.
  - Assert `reset` low mid-cycle and expect `state`=00 and `mem_err`=0 immediately.
- **Counter saturation**: `CNT_W`=4, with 20 consecutive load-use cycles.
  - Expect `stall_cnt`=15, held at 15 with no wrap.
- **Freeze over a mispredict**: a pending mispredict during MEM_WAIT.
  - Expect `redirect`=0 until the completing `mem_ready` cycle has passed.
  - Then expect `redirect`=1 in the first RUN cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use stalls, EX branch
// mispredict flushes, data-memory wait freeze with timeout, perf counters.
//
// state    | meaning
// RUN      | normal issue; hazards resolved combinationally
// MEM_WAIT | data memory busy; whole pipe frozen, MEM/WB bubbled
// HALT     | memory timed out; frozen until reset, mem_err set
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch,
    input  logic             ex_predicted,
    input  logic             ex_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             redirect,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    // wait_cnt holds the edges already spent waiting; the next one that
    // would reach MEM_TIMEOUT is the timeout edge.
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    state_t            stateQ, stateD;
    logic [WAIT_W-1:0] waitCnt, waitCntD;
    logic              memErrQ, memErrD;
    logic [CNT_W-1:0]  stallCntQ, flushCntQ;

    logic              memStall;
    logic              mispredictRaw;
    logic              loadUseRaw;
    logic              stallEvt;
    logic              flushEvt;

    assign memStall      = mem_req & ~mem_ready;
    assign mispredictRaw = ex_branch & (ex_predicted != ex_taken);
    assign loadUseRaw    = ex_mem_read & (ex_rd != 5'd0) &
                           ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ  <= RUN;
            waitCnt <= '0;
            memErrQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            waitCnt <= waitCntD;
            memErrQ <= memErrD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        waitCntD = waitCnt;
        memErrD  = memErrQ;
        case (stateQ)
            RUN: begin
                if (memStall) begin
                    stateD   = MEM_WAIT;
                    waitCntD = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    stateD   = RUN;
                    waitCntD = '0;
                end else if (waitCnt >= WAIT_LIMIT) begin
                    stateD   = HALT;
                    waitCntD = waitCnt + WAIT_W'(1);
                    memErrD  = 1'b1;
                end else begin
                    waitCntD = waitCnt + WAIT_W'(1);
                end
            end
            HALT: begin
                stateD = HALT;
            end
            default: begin
                stateD   = HALT;
                memErrD  = 1'b1;
            end
        endcase
    end

    // Priority: halt/freeze over mispredict over load-use.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        redirect     = 1'b0;
        stallEvt     = 1'b0;
        flushEvt     = 1'b0;
        if ((stateQ != RUN) || memStall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            stallEvt     = 1'b1;
        end else if (mispredictRaw) begin
            redirect     = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            flushEvt     = 1'b1;
        end else if (loadUseRaw) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
            stallEvt     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (stallEvt && (stallCntQ != CNT_MAX)) begin
                stallCntQ <= stallCntQ + CNT_W'(1);
            end
            if (flushEvt && (flushCntQ != CNT_MAX)) begin
                flushCntQ <= flushCntQ + CNT_W'(1);
            end
        end
    end

    assign state     = stateQ;
    assign mem_err   = memErrQ;
    assign stall_cnt = stallCntQ;
    assign flush_cnt = flushCntQ;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: combinational vector table in RUN,
// then memory wait, freeze-over-mispredict, timeout/reset and saturation runs.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, redirect}
    localparam logic [7:0] O_DEF  = 8'b11010100;
    localparam logic [7:0] O_LU   = 8'b00011100;
    localparam logic [7:0] O_MP   = 8'b11111101;
    localparam logic [7:0] O_FRZ  = 8'b00000010;

    logic clk, reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs2, ex_mem_read, ex_branch, ex_predicted, ex_taken, mem_req, mem_ready;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, redirect;
    logic mem_err;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int nCompared = 0;
    int nMismatched = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch(ex_branch), .ex_predicted(ex_predicted), .ex_taken(ex_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_bubble(memwb_bubble), .redirect(redirect),
        .mem_err(mem_err), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       usesRs2, memRead, br, pred, taken, req, ready;
        logic [7:0] expOut;
        logic       expStall, expFlush;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic u2,
                                logic mr, logic [4:0] rd, logic br, logic pr, logic tk,
                                logic rq, logic rdy, logic [7:0] eo, logic es, logic ef);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.usesRs2 = u2; v.memRead = mr; v.rd = rd;
        v.br = br; v.pred = pr; v.taken = tk; v.req = rq; v.ready = rdy;
        v.expOut = eo; v.expStall = es; v.expFlush = ef;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, redirect};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        ex_branch = 1'b0; ex_predicted = 1'b0; ex_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic setLoadUse();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int expStall;
        int expFlush;
        reset = 1'b0;
        idle();
        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_mem_err", 32'(mem_err), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("reset_outputs", 32'(outs()), 32'(O_DEF));
        @(negedge clk);
        reset = 1'b1;

        //                 name        rs1 rs2 u2 mr rd br pr tk rq rdy exp    st ef
        vecs[0]  = mk("idle",          1,  2,  0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, 0);
        vecs[1]  = mk("lu_rs1",        5,  2,  0, 1, 5, 0, 0, 0, 0, 0, O_LU,  1, 0);
        vecs[2]  = mk("lu_x0",         0,  0,  1, 1, 0, 0, 0, 0, 0, 0, O_DEF, 0, 0);
        vecs[3]  = mk("lu_rs2",        3,  7,  1, 1, 7, 0, 0, 0, 0, 0, O_LU,  1, 0);
        vecs[4]  = mk("rs2_unused",    3,  7,  0, 1, 7, 0, 0, 0, 0, 0, O_DEF, 0, 0);
        vecs[5]  = mk("load_nomatch",  3,  4,  1, 1, 9, 0, 0, 0, 0, 0, O_DEF, 0, 0);
        vecs[6]  = mk("nonload_match", 9,  4,  1, 0, 9, 0, 0, 0, 0, 0, O_DEF, 0, 0);
        vecs[7]  = mk("mp_pt_nt",      1,  2,  0, 0, 0, 1, 1, 0, 0, 0, O_MP,  0, 1);
        vecs[8]  = mk("mp_pn_t",       1,  2,  0, 0, 0, 1, 0, 1, 0, 0, O_MP,  0, 1);
        vecs[9]  = mk("br_correct",    1,  2,  0, 0, 0, 1, 1, 1, 0, 0, O_DEF, 0, 0);
        vecs[10] = mk("mp_over_lu",    5,  2,  0, 1, 5, 1, 1, 0, 0, 0, O_MP,  0, 1);
        vecs[11] = mk("nobr_diff",     1,  2,  0, 0, 0, 0, 1, 0, 0, 0, O_DEF, 0, 0);
        vecs[12] = mk("mem1_lu",       5,  2,  0, 1, 5, 0, 0, 0, 1, 1, O_LU,  1, 0);
        vecs[13] = mk("mem1_mp",       1,  2,  0, 0, 0, 1, 0, 1, 1, 1, O_MP,  0, 1);

        expStall = 0;
        expFlush = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_uses_rs2 = vecs[i].usesRs2;
            ex_mem_read = vecs[i].memRead; ex_rd = vecs[i].rd;
            ex_branch = vecs[i].br; ex_predicted = vecs[i].pred; ex_taken = vecs[i].taken;
            mem_req = vecs[i].req; mem_ready = vecs[i].ready;
            #1;
            chk({vecs[i].name, "_outs"}, 32'(outs()), 32'(vecs[i].expOut));
            chk({vecs[i].name, "_state"}, 32'(state), 32'd0);
            chk({vecs[i].name, "_stall_cnt"}, 32'(stall_cnt), 32'(expStall));
            chk({vecs[i].name, "_flush_cnt"}, 32'(flush_cnt), 32'(expFlush));
            expStall += int'(vecs[i].expStall);
            expFlush += int'(vecs[i].expFlush);
        end
        @(negedge clk);
        idle();
        #1;
        chk("table_stall_total", 32'(stall_cnt), 32'(expStall));
        chk("table_flush_total", 32'(flush_cnt), 32'(expFlush));

        // 3-cycle memory wait with a mispredicted branch pending in EX
        doReset();
        mem_req = 1'b1; mem_ready = 1'b0;
        ex_branch = 1'b1; ex_predicted = 1'b1; ex_taken = 1'b0;
        #1;
        chk("mw_c0_outs", 32'(outs()), 32'(O_FRZ));
        chk("mw_c0_state", 32'(state), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) mem_ready = 1'b1;
            #1;
            chk($sformatf("mw_c%0d_outs", c), 32'(outs()), 32'(O_FRZ));
            chk($sformatf("mw_c%0d_state", c), 32'(state), 32'd1);
        end
        @(negedge clk);
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("mw_done_state", 32'(state), 32'd0);
        chk("mw_done_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("mw_done_redirect_outs", 32'(outs()), 32'(O_MP));
        chk("mw_done_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("mw_after_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("mw_after_outs", 32'(outs()), 32'(O_DEF));

        // Memory timeout into HALT, then asynchronous reset mid-cycle
        doReset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_c%0d_state", c), 32'(state), 32'd1);
            chk($sformatf("to_c%0d_mem_err", c), 32'(mem_err), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("to_halt_state", 32'(state), 32'd2);
        chk("to_halt_mem_err", 32'(mem_err), 32'd1);
        chk("to_halt_outs", 32'(outs()), 32'(O_FRZ));
        chk("to_halt_stall_cnt", 32'(stall_cnt), 32'd4);
        mem_ready = 1'b1;
        ex_branch = 1'b1; ex_predicted = 1'b0; ex_taken = 1'b1;
        #1;
        chk("to_halt_ready_outs", 32'(outs()), 32'(O_FRZ));
        for (int c = 5; c <= 6; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_hold%0d_state", c), 32'(state), 32'd2);
            chk($sformatf("to_hold%0d_outs", c), 32'(outs()), 32'(O_FRZ));
            chk($sformatf("to_hold%0d_stall_cnt", c), 32'(stall_cnt), 32'(c));
        end
        #2;
        reset = 1'b0;
        #1;
        chk("to_rst_state", 32'(state), 32'd0);
        chk("to_rst_mem_err", 32'(mem_err), 32'd0);
        chk("to_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("to_rst_outs", 32'(outs()), 32'(O_MP));
        @(negedge clk);
        reset = 1'b1;
        idle();

        // Consecutive load-use cycles saturate the 4-bit stall counter
        doReset();
        setLoadUse();
        for (int c = 0; c < 20; c++) begin
            #1;
            chk($sformatf("sat_c%0d_stall_cnt", c), 32'(stall_cnt), 32'(c > 15 ? 15 : c));
            chk($sformatf("sat_c%0d_outs", c), 32'(outs()), 32'(O_LU));
            @(negedge clk);
        end
        idle();
        #1;
        chk("sat_final_stall_cnt", 32'(stall_cnt), 32'd15);
        @(negedge clk);
        #1;
        chk("sat_hold_stall_cnt", 32'(stall_cnt), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
